xf100_exu_wbck: RTL and testbench
=================================

// Module: xf100_exu_wbck
// PURPOSE
//   Write-back arbiter directly upstream of the regfile write port.
//   - Merges two result sources: the single-cycle ALU and the long-pipe unit (LSU/MULDIV).
//   - Grants at most one source per cycle and registers the winner for one cycle.
//   - Drives the regfile write port from that register.
//   - The same registered signals serve as the decode bypass source.
// PARAMETERS
//   STARVE_MAX  3                       consecutive ALU-blocked cycles before the ALU is forced the grant
//   STARVE_CW   $clog2(STARVE_MAX+1)    starvation counter width (derived, not overridden)
//   Widths come from `XF100_XLEN (32) and `XF100_RFIDX_WIDTH (5).
// PORTS
//   clk                 in   1            core clock
//   rst                 in   1            asynchronous, active-high reset
//   alu_i_wbck_valid    in   1            ALU result valid
//   alu_o_wbck_ready    out  1            ALU result accepted this cycle
//   alu_i_wbck_data     in   XLEN         ALU result
//   alu_i_wbck_rdidx    in   RFIDX_WIDTH  ALU destination register
//   longp_i_wbck_valid  in   1            long-pipe result valid
//   longp_o_wbck_ready  out  1            long-pipe result accepted this cycle
//   longp_i_wbck_data   in   XLEN         long-pipe result
//   longp_i_wbck_rdidx  in   RFIDX_WIDTH  long-pipe destination register
//   rf_o_wr_en          out  1            regfile write enable (registered)
//   rf_o_wr_data        out  XLEN         regfile write data (registered)
//   rf_o_wr_rdidx       out  RFIDX_WIDTH  regfile write index (registered)
// BEHAVIOUR
//   Reset: rf_o_wr_en=0, rf_o_wr_data=0, rf_o_wr_rdidx=0, starve_cnt=0; applied asynchronously.
//   Handshake
//   - Per source: valid/ready. A transfer occurs when valid & ready are both high at the clk edge.
//   - valid must not depend on ready. ready is combinational from both valids and starve_cnt.
//   - Once raised, valid is held, with data/rdidx stable, until the transfer.
//   Grant (combinational)
//   - force_alu = alu_valid & (starve_cnt == STARVE_MAX).
//   - grant_longp = longp_valid & ~force_alu.
//   - grant_alu = alu_valid & ~grant_longp.
//   - alu_o_wbck_ready = grant_alu; longp_o_wbck_ready = grant_longp.
//   - Both idle: both readies are 0 and no transfer occurs.
//   Starvation counter
//   - Cleared to 0 when alu_valid=0 or grant_alu=1.
//   - Otherwise incremented, saturating at STARVE_MAX.
//   Output register (latency 1)
//   - On a transfer, rf_o_wr_data/rf_o_wr_rdidx <= the granted source's data/rdidx.
//   - Same edge: rf_o_wr_en <= (rdidx != 0). x0 writes are consumed but never asserted.
//   - With no transfer, rf_o_wr_en <= 0 and data/rdidx hold their values.
//   - Throughput: one write per cycle. The regfile never back-pressures, so there is no stall input.
//   Bypass: decode compares its rs index against rf_o_wr_rdidx when rf_o_wr_en=1. The regfile
//     returns the pre-write value in that cycle.
//   Ordering
//   - WAW between in-flight long-pipe and ALU results to the same rd is prevented by issue.
//   - If both sources present the same rdidx in one cycle, they are still serialised per the grant
//     rules, with no merging.
//   Reset mid-operation: a pending output write is dropped and starve_cnt returns to 0. Sources
//     re-present after reset release.
// STRUCTURE
//   - Shared defines (xf100_defines.v): reuse `XF100_XLEN and `XF100_RFIDX_WIDTH; add
//     `XF100_WBCK_STARVE_MAX (3) as the default for STARVE_MAX.
//   - One sub-module, xf100_exu_wbck_arb: grant logic plus starvation counter. It outputs
//     grant_alu/grant_longp.
//   - Top level holds the source mux, the x0 check and the output register (async active-high
//     reset flops).
// TESTING
//   1. ALU only: valid, rd=5, data=0x1234 -> ready=1 same cycle; next cycle wr_en=1, rdidx=5,
//      data=0x1234; then wr_en=0.
//   2. Collision: both valid, ALU rd=3/0xA, longp rd=4/0xB -> longp granted first (wr rd=4, 0xB);
//      ALU granted the next cycle (wr rd=3, 0xA, one cycle later).
//   3. Starvation: ALU held valid, longp valid every cycle -> ALU ready=0 for 3 cycles, forced on
//      the 4th with longp ready=0; counter is 0 again afterward.
//   4. x0: longp valid, rd=0, data=0xFFFFFFFF -> ready=1; next cycle wr_en=0;
//      rf_o_wr_rdidx=0, rf_o_wr_data=0xFFFFFFFF.
//   5. Back-to-back: ALU rd=1..8 on consecutive cycles -> eight consecutive wr_en=1 cycles,
//      indices 1..8 in order with no bubbles.
//   6. Reset: assert rst while wr_en=1 -> wr_en, data and rdidx read 0 before the next clk edge;
//      starve_cnt=0 after release.

Source files
------------

// File: rtl/xf100_exu_wbck_pkg.sv
// Shared widths and types for the write-back arbiter slice.
// The XF100 core-wide width macros are honoured when already defined elsewhere.

`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_RFIDX_WIDTH
`define XF100_RFIDX_WIDTH 5
`endif
`ifndef XF100_WBCK_STARVE_MAX
`define XF100_WBCK_STARVE_MAX 3
`endif

package xf100_exu_wbck_pkg;

    localparam int XLEN            = `XF100_XLEN;
    localparam int RFIDX_WIDTH     = `XF100_RFIDX_WIDTH;
    localparam int WBCK_STARVE_MAX = `XF100_WBCK_STARVE_MAX;

    // One write-back request as presented by a result source
    typedef struct packed {
        logic [XLEN-1:0]        data;
        logic [RFIDX_WIDTH-1:0] rdidx;
    } wbck_req_t;

    // x0 is hard-wired to zero, so writes to it are swallowed
    function automatic logic is_x0(input logic [RFIDX_WIDTH-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/xf100_exu_wbck_arb.sv
// Grant logic for the write-back port: the long pipe normally wins, but an ALU
// result that has been blocked STARVE_MAX cycles in a row is forced through.

module xf100_exu_wbck_arb
    import xf100_exu_wbck_pkg::*;
#(
    parameter int STARVE_MAX = WBCK_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic longp_valid,
    output logic grant_alu,
    output logic grant_longp
);

    localparam int STARVE_CW = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_CW-1:0] STARVE_LIMIT = STARVE_CW'(STARVE_MAX);

    logic [STARVE_CW-1:0] starve_cnt;
    logic                 force_alu;

    // Priority decision: long pipe first unless the ALU has waited long enough
    always_comb begin
        force_alu   = alu_valid & (starve_cnt == STARVE_LIMIT);
        grant_longp = longp_valid & ~force_alu;
        grant_alu   = alu_valid & ~grant_longp;
    end

    // Count consecutive cycles an ALU result is presented but not accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!alu_valid || grant_alu) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xf100_exu_wbck.sv
// Write-back stage feeding the regfile write port. Picks one of the ALU or
// long-pipe results per cycle and registers it; the registered port also acts
// as the bypass source seen by decode.

module xf100_exu_wbck
    import xf100_exu_wbck_pkg::*;
#(
    parameter int STARVE_MAX = WBCK_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_i_wbck_valid,
    output logic                   alu_o_wbck_ready,
    input  logic [XLEN-1:0]        alu_i_wbck_data,
    input  logic [RFIDX_WIDTH-1:0] alu_i_wbck_rdidx,
    input  logic                   longp_i_wbck_valid,
    output logic                   longp_o_wbck_ready,
    input  logic [XLEN-1:0]        longp_i_wbck_data,
    input  logic [RFIDX_WIDTH-1:0] longp_i_wbck_rdidx,
    output logic                   rf_o_wr_en,
    output logic [XLEN-1:0]        rf_o_wr_data,
    output logic [RFIDX_WIDTH-1:0] rf_o_wr_rdidx
);

    logic      grant_alu;
    logic      grant_longp;
    logic      transfer;
    wbck_req_t win_req;

    xf100_exu_wbck_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_i_wbck_valid),
        .longp_valid (longp_i_wbck_valid),
        .grant_alu   (grant_alu),
        .grant_longp (grant_longp)
    );

    assign alu_o_wbck_ready   = grant_alu;
    assign longp_o_wbck_ready = grant_longp;

    // Select the winning source; grants are one-hot so a simple mux suffices
    always_comb begin
        transfer = grant_alu | grant_longp;
        if (grant_longp) begin
            win_req = '{data: longp_i_wbck_data, rdidx: longp_i_wbck_rdidx};
        end else begin
            win_req = '{data: alu_i_wbck_data, rdidx: alu_i_wbck_rdidx};
        end
    end

    // Register the accepted result; data/index hold when idle so bypass stays stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_o_wr_en    <= 1'b0;
            rf_o_wr_data  <= '0;
            rf_o_wr_rdidx <= '0;
        end else if (transfer) begin
            rf_o_wr_en    <= ~is_x0(win_req.rdidx);
            rf_o_wr_data  <= win_req.data;
            rf_o_wr_rdidx <= win_req.rdidx;
        end else begin
            rf_o_wr_en    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// Self-checking bench for the write-back arbiter: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.

module tb_xf100_exu_wbck;

    localparam int STARVE_LIMIT = 3;

    logic        clk;
    logic        rst;
    logic        alu_i_wbck_valid;
    logic        alu_o_wbck_ready;
    logic [31:0] alu_i_wbck_data;
    logic [4:0]  alu_i_wbck_rdidx;
    logic        longp_i_wbck_valid;
    logic        longp_o_wbck_ready;
    logic [31:0] longp_i_wbck_data;
    logic [4:0]  longp_i_wbck_rdidx;
    logic        rf_o_wr_en;
    logic [31:0] rf_o_wr_data;
    logic [4:0]  rf_o_wr_rdidx;

    xf100_exu_wbck dut (
        .clk                (clk),
        .rst                (rst),
        .alu_i_wbck_valid   (alu_i_wbck_valid),
        .alu_o_wbck_ready   (alu_o_wbck_ready),
        .alu_i_wbck_data    (alu_i_wbck_data),
        .alu_i_wbck_rdidx   (alu_i_wbck_rdidx),
        .longp_i_wbck_valid (longp_i_wbck_valid),
        .longp_o_wbck_ready (longp_o_wbck_ready),
        .longp_i_wbck_data  (longp_i_wbck_data),
        .longp_i_wbck_rdidx (longp_i_wbck_rdidx),
        .rf_o_wr_en         (rf_o_wr_en),
        .rf_o_wr_data       (rf_o_wr_data),
        .rf_o_wr_rdidx      (rf_o_wr_rdidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Source-side state: each source holds its request until accepted
    logic        aPend, lPend;
    logic [31:0] aData, lData;
    logic [4:0]  aIdx,  lIdx;

    // Reference model state
    int          waitCycles;
    logic        expEn;
    logic [31:0] expData;
    logic [4:0]  expIdx;
    logic        lastAluReady;
    logic        lastLongpReady;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        waitCycles = 0;
        expEn      = 1'b0;
        expData    = '0;
        expIdx     = '0;
    endtask

    // One clock cycle: drive at negedge, check readies, advance, check the write port
    task automatic applyStimulus();
        logic predLongp, predAlu;
        alu_i_wbck_valid   = aPend;
        alu_i_wbck_data    = aData;
        alu_i_wbck_rdidx   = aIdx;
        longp_i_wbck_valid = lPend;
        longp_i_wbck_data  = lData;
        longp_i_wbck_rdidx = lIdx;
        #1;
        predLongp = lPend && !(aPend && waitCycles >= STARVE_LIMIT);
        predAlu   = aPend && !predLongp;
        lastAluReady   = alu_o_wbck_ready;
        lastLongpReady = longp_o_wbck_ready;
        checkOutput("alu_ready", {31'd0, alu_o_wbck_ready}, {31'd0, predAlu});
        checkOutput("longp_ready", {31'd0, longp_o_wbck_ready}, {31'd0, predLongp});
        @(posedge clk);
        if (predLongp) begin
            expEn = (lIdx != 0); expData = lData; expIdx = lIdx;
            lPend = 1'b0;
        end else if (predAlu) begin
            expEn = (aIdx != 0); expData = aData; expIdx = aIdx;
            aPend = 1'b0;
        end else begin
            expEn = 1'b0;
        end
        if (aPend) waitCycles = (waitCycles < STARVE_LIMIT) ? waitCycles + 1 : STARVE_LIMIT;
        else       waitCycles = 0;
        #1;
        checkOutput("wr_en", {31'd0, rf_o_wr_en}, {31'd0, expEn});
        checkOutput("wr_data", rf_o_wr_data, expData);
        checkOutput("wr_rdidx", {27'd0, rf_o_wr_rdidx}, {27'd0, expIdx});
        @(negedge clk);
    endtask

    task automatic setAlu(input logic [4:0] idx, input logic [31:0] data);
        aPend = 1'b1; aIdx = idx; aData = data;
    endtask

    task automatic setLongp(input logic [4:0] idx, input logic [31:0] data);
        lPend = 1'b1; lIdx = idx; lData = data;
    endtask

    initial begin
        rst = 1'b1;
        aPend = 0; lPend = 0; aData = 0; lData = 0; aIdx = 0; lIdx = 0;
        alu_i_wbck_valid = 0; alu_i_wbck_data = 0; alu_i_wbck_rdidx = 0;
        longp_i_wbck_valid = 0; longp_i_wbck_data = 0; longp_i_wbck_rdidx = 0;
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_wr_en", {31'd0, rf_o_wr_en}, 32'd0);
        checkOutput("reset_wr_data", rf_o_wr_data, 32'd0);
        checkOutput("reset_wr_rdidx", {27'd0, rf_o_wr_rdidx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ALU only");
        setAlu(5'd5, 32'h1234);
        applyStimulus();
        applyStimulus();

        $display("[TB] collision");
        setAlu(5'd3, 32'hA);
        setLongp(5'd4, 32'hB);
        applyStimulus();
        checkOutput("collision_first_rd", {27'd0, rf_o_wr_rdidx}, 32'd4);
        applyStimulus();
        checkOutput("collision_second_rd", {27'd0, rf_o_wr_rdidx}, 32'd3);
        applyStimulus();

        $display("[TB] starvation");
        setAlu(5'd9, 32'h99);
        for (int i = 0; i < 4; i++) begin
            setLongp(5'(10 + i), 32'h100 + i);
            applyStimulus();
            checkOutput("starve_alu_ready_seq", {31'd0, lastAluReady}, (i == 3) ? 32'd1 : 32'd0);
        end
        // After the forced grant the ALU must again wait behind the long pipe
        setAlu(5'd20, 32'h20);
        for (int i = 0; i < 4; i++) begin
            setLongp(5'(21 + i), 32'h200 + i);
            applyStimulus();
        end
        applyStimulus();

        $display("[TB] x0 write");
        setLongp(5'd0, 32'hFFFF_FFFF);
        applyStimulus();
        applyStimulus();

        $display("[TB] back-to-back");
        for (int i = 1; i <= 8; i++) begin
            setAlu(5'(i), 32'hC000 + i);
            applyStimulus();
        end

        $display("[TB] reset mid-operation");
        setAlu(5'd2, 32'h22);
        setLongp(5'd6, 32'h66);
        applyStimulus();
        setLongp(5'd7, 32'h77);
        applyStimulus();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_wr_en", {31'd0, rf_o_wr_en}, 32'd0);
        checkOutput("midrst_wr_data", rf_o_wr_data, 32'd0);
        checkOutput("midrst_wr_rdidx", {27'd0, rf_o_wr_rdidx}, 32'd0);
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!lPend) setLongp(5'(12 + i), 32'h300 + i);
            applyStimulus();
        end
        applyStimulus();

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if (!aPend && ($urandom_range(0, 3) != 0)) setAlu(5'($urandom_range(0, 31)), $urandom);
            if (!lPend && ($urandom_range(0, 2) != 0)) setLongp(5'($urandom_range(0, 31)), $urandom);
            applyStimulus();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
